// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, issue and writeback signal bundle for regfile_sb.
// Latency: none (wires only).
// Backpressure: iss_stall refuses an issue; writebacks are never refused.
//
// master: decode/writeback side (drives addresses, enables, write data)
// slave : register file side (drives read data, busy flags, iss_stall)
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int AW     = 4
);
   logic [AW-1:0]     rd_addr_a;
   logic [AW-1:0]     rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              rd_busy_a;
   logic              rd_busy_b;

   logic              iss_en;
   logic [AW-1:0]     iss_addr;
   logic              iss_stall;

   logic              wr_en0;
   logic [AW-1:0]     wr_addr0;
   logic [DATA_W-1:0] wr_data0;
   logic              wr_en1;
   logic [AW-1:0]     wr_addr1;
   logic [DATA_W-1:0] wr_data1;

   modport master (
      output rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
      output iss_en, iss_addr,
      input  iss_stall,
      output wr_en0, wr_addr0, wr_data0,
      output wr_en1, wr_addr1, wr_data1
   );

   modport slave (
      input  rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
      input  iss_en, iss_addr,
      output iss_stall,
      input  wr_en0, wr_addr0, wr_data0,
      input  wr_en1, wr_addr1, wr_data1
   );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with per-register outstanding-write counters.
// Latency: reads 0 cycles, writes/issues visible 1 cycle later (0 for written data with RF_BYPASS_EN).
// Backpressure: iss_stall when the issued register's counter is saturated; writes always accepted.
//
// Ports: clk, rst (async, active-high), rf (regfile_sb_if.slave: two read ports
// with busy flags, issue port with stall, writeback port 0 = ALU, port 1 = load).
// Optional feature macro: RF_BYPASS_EN (write-to-read forwarding, busy from post-decrement count).
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int AW     = 4,
   parameter int CNT_W  = 2
) (
   input  logic        clk,
   input  logic        rst,
   regfile_sb_if.slave rf
);
   localparam int NREGS = 2 ** AW;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0] mem     [NREGS];
   logic [CNT_W-1:0]  cnt     [NREGS];
   logic [CNT_W-1:0]  cnt_nxt [NREGS];
   logic [CNT_W:0]    sum     [NREGS];
   logic [CNT_W:0]    dec     [NREGS];
   logic              iss_stall;
   logic              iss_ok;

   // Stall uses the pre-edge count, so a refused issue never touches the counter.
   assign iss_stall    = rf.iss_en && (cnt[rf.iss_addr] == CNT_MAX);
   assign iss_ok       = rf.iss_en && !iss_stall;
   assign rf.iss_stall = iss_stall;

   // Counter arithmetic is one bit wider so cnt + inc - dec can be clamped at 0
   // instead of wrapping when writebacks arrive for a register with nothing pending.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         dec[r] = (CNT_W+1)'(rf.wr_en0 && (rf.wr_addr0 == AW'(r)))
                + (CNT_W+1)'(rf.wr_en1 && (rf.wr_addr1 == AW'(r)));
         sum[r] = {1'b0, cnt[r]} + (CNT_W+1)'(iss_ok && (rf.iss_addr == AW'(r)));
         cnt_nxt[r] = (sum[r] > dec[r]) ? CNT_W'(sum[r] - dec[r]) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            mem[r] <= '0;
            cnt[r] <= '0;
         end
      end else begin
         if (rf.wr_en0) mem[rf.wr_addr0] <= rf.wr_data0;
         // Port 1 is assigned last so it wins a same-address collision.
         if (rf.wr_en1) mem[rf.wr_addr1] <= rf.wr_data1;
         for (int r = 0; r < NREGS; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
      end
   end

`ifdef RF_BYPASS_EN
   // Forward in-flight write data (port 1 over port 0); suppressed during reset
   // because those writes are discarded.
   always_comb begin
      rf.rd_data_a = mem[rf.rd_addr_a];
      if (!rst && rf.wr_en0 && (rf.wr_addr0 == rf.rd_addr_a)) rf.rd_data_a = rf.wr_data0;
      if (!rst && rf.wr_en1 && (rf.wr_addr1 == rf.rd_addr_a)) rf.rd_data_a = rf.wr_data1;
   end

   always_comb begin
      rf.rd_data_b = mem[rf.rd_addr_b];
      if (!rst && rf.wr_en0 && (rf.wr_addr0 == rf.rd_addr_b)) rf.rd_data_b = rf.wr_data0;
      if (!rst && rf.wr_en1 && (rf.wr_addr1 == rf.rd_addr_b)) rf.rd_data_b = rf.wr_data1;
   end

   // Busy if anything remains after this cycle's writebacks; same-cycle issue ignored.
   assign rf.rd_busy_a = ({1'b0, cnt[rf.rd_addr_a]} > dec[rf.rd_addr_a]);
   assign rf.rd_busy_b = ({1'b0, cnt[rf.rd_addr_b]} > dec[rf.rd_addr_b]);
`else
   assign rf.rd_data_a = mem[rf.rd_addr_a];
   assign rf.rd_data_b = mem[rf.rd_addr_b];
   assign rf.rd_busy_a = (cnt[rf.rd_addr_a] != '0);
   assign rf.rd_busy_b = (cnt[rf.rd_addr_b] != '0);
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb.
// Latency: checks combinational reads 1 ns after driving, stored state after the edge.
// Backpressure: exercises iss_stall on counter saturation.
module tb_regfile_sb;
   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;

`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_sb_if #(.DATA_W(32), .AW(4)) rf ();

   regfile_sb #(.DATA_W(32), .AW(4), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .rf  (rf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic idle();
      rf.iss_en   = 1'b0;
      rf.iss_addr = '0;
      rf.wr_en0   = 1'b0;
      rf.wr_addr0 = '0;
      rf.wr_data0 = '0;
      rf.wr_en1   = 1'b0;
      rf.wr_addr1 = '0;
      rf.wr_data1 = '0;
   endtask

   // Inputs change 2 ns after the rising edge, well away from it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      rf.rd_addr_a = '0;
      rf.rd_addr_b = '0;
      tick();
      for (int i = 0; i < 16; i++) begin
         rf.rd_addr_a = 4'(i);
         rf.rd_addr_b = 4'(15 - i);
         #1;
         tests++;
         if (rf.rd_data_a !== 32'h0) begin fails++; $display("FAIL reset_data_a r%0d: got %h want 0", i, rf.rd_data_a); end
         tests++;
         if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a r%0d: got %b want 0", i, rf.rd_busy_a); end
         tests++;
         if (rf.rd_data_b !== 32'h0) begin fails++; $display("FAIL reset_data_b r%0d: got %h want 0", 15 - i, rf.rd_data_b); end
         tests++;
         if (rf.rd_busy_b !== 1'b0) begin fails++; $display("FAIL reset_busy_b r%0d: got %b want 0", 15 - i, rf.rd_busy_b); end
      end
      rf.iss_en = 1'b1;
      rf.iss_addr = 4'd0;
      #1;
      tests++;
      if (rf.iss_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", rf.iss_stall); end
      idle();
      rst = 1'b0;
      tick();

      // Normal write of r3 so the later reset has something to clear.
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd3; rf.wr_data0 = 32'h1111;
      tick();
      idle();
      rf.rd_addr_a = 4'd3;
      #1;
      tests++;
      if (rf.rd_data_a !== 32'h1111) begin fails++; $display("FAIL pre_reset_write: got %h want 00001111", rf.rd_data_a); end

      // Reset asserted while a write of 0xDEAD is pending on the next edge.
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd3; rf.wr_data0 = 32'hDEAD;
      #1;
      rst = 1'b1;
      #1;
      tests++;
      if (rf.rd_data_a !== 32'h0) begin fails++; $display("FAIL mid_write_async_clear: got %h want 0", rf.rd_data_a); end
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_data_a !== 32'h0) begin fails++; $display("FAIL write_during_reset: got %h want 0", rf.rd_data_a); end
      rst = 1'b0;
      tick();
      #1;
      tests++;
      if (rf.rd_data_a !== 32'h0) begin fails++; $display("FAIL after_reset_r3: got %h want 0", rf.rd_data_a); end
   endtask

   task automatic test_issue_write();
      rf.rd_addr_a = 4'd2;
      rf.iss_en = 1'b1; rf.iss_addr = 4'd2;
      #1;
      tests++;
      if (rf.iss_stall !== 1'b0) begin fails++; $display("FAIL iw_stall: got %b want 0", rf.iss_stall); end
      tests++;
      if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL iw_busy_pre: got %b want 0", rf.rd_busy_a); end
      tick();
      idle();
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd2; rf.wr_data0 = 32'h12345678;
      #1;
      tests++;
      if (rf.rd_busy_a !== !BYP) begin fails++; $display("FAIL iw_busy_wcycle: got %b want %b", rf.rd_busy_a, !BYP); end
      tests++;
      if (rf.rd_data_a !== (BYP ? 32'h12345678 : 32'h0)) begin fails++; $display("FAIL iw_data_wcycle: got %h want %h", rf.rd_data_a, (BYP ? 32'h12345678 : 32'h0)); end
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL iw_busy_after: got %b want 0", rf.rd_busy_a); end
      tests++;
      if (rf.rd_data_a !== 32'h12345678) begin fails++; $display("FAIL iw_data_after: got %h want 12345678", rf.rd_data_a); end
   endtask

   task automatic test_dual_write();
      rf.rd_addr_a = 4'd5;
      rf.iss_en = 1'b1; rf.iss_addr = 4'd5;
      tick();
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_busy_a !== 1'b1) begin fails++; $display("FAIL dw_busy_cnt2: got %b want 1", rf.rd_busy_a); end
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd5; rf.wr_data0 = 32'h1;
      rf.wr_en1 = 1'b1; rf.wr_addr1 = 4'd5; rf.wr_data1 = 32'h2;
      #1;
      tests++;
      if (rf.rd_data_a !== (BYP ? 32'h2 : 32'h0)) begin fails++; $display("FAIL dw_data_wcycle: got %h want %h", rf.rd_data_a, (BYP ? 32'h2 : 32'h0)); end
      tests++;
      if (rf.rd_busy_a !== !BYP) begin fails++; $display("FAIL dw_busy_wcycle: got %b want %b", rf.rd_busy_a, !BYP); end
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_data_a !== 32'h2) begin fails++; $display("FAIL dw_port1_wins: got %h want 2", rf.rd_data_a); end
      tests++;
      if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL dw_cnt2_to_0: got %b want 0", rf.rd_busy_a); end

      // Count of 1 with two writebacks must clamp to 0, not wrap.
      rf.iss_en = 1'b1; rf.iss_addr = 4'd5;
      tick();
      idle();
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd5; rf.wr_data0 = 32'h3;
      rf.wr_en1 = 1'b1; rf.wr_addr1 = 4'd5; rf.wr_data1 = 32'h4;
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_data_a !== 32'h4) begin fails++; $display("FAIL dw_clamp_data: got %h want 4", rf.rd_data_a); end
      tests++;
      if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL dw_clamp_busy: got %b want 0", rf.rd_busy_a); end
   endtask

   task automatic test_saturate();
      rf.rd_addr_b = 4'd7;
      for (int k = 0; k < 3; k++) begin
         rf.iss_en = 1'b1; rf.iss_addr = 4'd7;
         #1;
         tests++;
         if (rf.iss_stall !== 1'b0) begin fails++; $display("FAIL sat_stall_issue%0d: got %b want 0", k, rf.iss_stall); end
         tick();
      end
      #1;
      tests++;
      if (rf.iss_stall !== 1'b1) begin fails++; $display("FAIL sat_stall_4th: got %b want 1", rf.iss_stall); end
      tick();
      #1;
      tests++;
      if (rf.iss_stall !== 1'b1) begin fails++; $display("FAIL sat_cnt_held: got %b want 1", rf.iss_stall); end
      idle();
      #1;
      tests++;
      if (rf.iss_stall !== 1'b0) begin fails++; $display("FAIL sat_stall_no_en: got %b want 0", rf.iss_stall); end
      tests++;
      if (rf.rd_busy_b !== 1'b1) begin fails++; $display("FAIL sat_busy: got %b want 1", rf.rd_busy_b); end
      for (int k = 0; k < 3; k++) begin
         rf.wr_en1 = 1'b1; rf.wr_addr1 = 4'd7; rf.wr_data1 = 32'h70 + 32'(k);
         tick();
         idle();
         #1;
         tests++;
         if (rf.rd_busy_b !== (k < 2)) begin fails++; $display("FAIL sat_wb%0d_busy: got %b want %b", k, rf.rd_busy_b, (k < 2)); end
      end
      tests++;
      if (rf.rd_data_b !== 32'h72) begin fails++; $display("FAIL sat_data: got %h want 72", rf.rd_data_b); end
   endtask

   task automatic test_same_cycle();
      rf.rd_addr_a = 4'd4;
      rf.iss_en = 1'b1; rf.iss_addr = 4'd4;
      tick();
      idle();
      rf.iss_en = 1'b1; rf.iss_addr = 4'd4;
      rf.wr_en1 = 1'b1; rf.wr_addr1 = 4'd4; rf.wr_data1 = 32'hAA;
      #1;
      tests++;
      if (rf.iss_stall !== 1'b0) begin fails++; $display("FAIL sc_stall: got %b want 0", rf.iss_stall); end
      tests++;
      if (rf.rd_busy_a !== !BYP) begin fails++; $display("FAIL sc_busy_wcycle: got %b want %b", rf.rd_busy_a, !BYP); end
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_busy_a !== 1'b1) begin fails++; $display("FAIL sc_busy_held: got %b want 1", rf.rd_busy_a); end
      tests++;
      if (rf.rd_data_a !== 32'hAA) begin fails++; $display("FAIL sc_data: got %h want aa", rf.rd_data_a); end
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd4; rf.wr_data0 = 32'hBB;
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL sc_busy_cleared: got %b want 0", rf.rd_busy_a); end
      tests++;
      if (rf.rd_data_a !== 32'hBB) begin fails++; $display("FAIL sc_data2: got %h want bb", rf.rd_data_a); end
   endtask

   task automatic test_write_idle();
      rf.rd_addr_a = 4'd1;
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd1; rf.wr_data0 = 32'h55;
      #1;
      tests++;
      if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL wi_busy_wcycle: got %b want 0", rf.rd_busy_a); end
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL wi_busy_after: got %b want 0", rf.rd_busy_a); end
      tests++;
      if (rf.rd_data_a !== 32'h55) begin fails++; $display("FAIL wi_data: got %h want 55", rf.rd_data_a); end
      // A single issue then a single writeback must round-trip from 0.
      rf.iss_en = 1'b1; rf.iss_addr = 4'd1;
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_busy_a !== 1'b1) begin fails++; $display("FAIL wi_busy_issued: got %b want 1", rf.rd_busy_a); end
      rf.wr_en1 = 1'b1; rf.wr_addr1 = 4'd1; rf.wr_data1 = 32'h66;
      tick();
      idle();
      #1;
      tests++;
      if (rf.rd_busy_a !== 1'b0) begin fails++; $display("FAIL wi_busy_wb: got %b want 0", rf.rd_busy_a); end
      tests++;
      if (rf.rd_data_a !== 32'h66) begin fails++; $display("FAIL wi_data2: got %h want 66", rf.rd_data_a); end
   endtask

   task automatic test_back_to_back();
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd8; rf.wr_data0 = 32'hA0A0;
      rf.wr_en1 = 1'b1; rf.wr_addr1 = 4'd9; rf.wr_data1 = 32'hB1B1;
      tick();
      rf.wr_en0 = 1'b1; rf.wr_addr0 = 4'd8;  rf.wr_data0 = 32'hC2C2;
      rf.wr_en1 = 1'b1; rf.wr_addr1 = 4'd10; rf.wr_data1 = 32'hD3D3;
      rf.rd_addr_a = 4'd8;
      rf.rd_addr_b = 4'd9;
      #1;
      tests++;
      if (rf.rd_data_a !== (BYP ? 32'hC2C2 : 32'hA0A0)) begin fails++; $display("FAIL b2b_r8_first: got %h want %h", rf.rd_data_a, (BYP ? 32'hC2C2 : 32'hA0A0)); end
      tests++;
      if (rf.rd_data_b !== 32'hB1B1) begin fails++; $display("FAIL b2b_r9: got %h want b1b1", rf.rd_data_b); end
      tick();
      idle();
      rf.rd_addr_b = 4'd10;
      #1;
      tests++;
      if (rf.rd_data_a !== 32'hC2C2) begin fails++; $display("FAIL b2b_r8_second: got %h want c2c2", rf.rd_data_a); end
      tests++;
      if (rf.rd_data_b !== 32'hD3D3) begin fails++; $display("FAIL b2b_r10: got %h want d3d3", rf.rd_data_b); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      rf.rd_addr_a = '0;
      rf.rd_addr_b = '0;
      test_reset();
      test_issue_write();
      test_dual_write();
      test_saturate();
      test_same_cycle();
      test_write_idle();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read/two-write register file with a per-register outstanding-write scoreboard for the ARM pipeline. It sits between decode (read/issue) and writeback (ALU result port 0, memory-load port 1). It holds architectural register contents and tracks in-flight writes so decode can detect RAW hazards. It replaces the fixed 16x32 single-write-port file.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- AW, 4, address width; NREGS = 2**AW registers
- CNT_W, 2, outstanding-write counter width per register; max in flight = 2**CNT_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset rst, asynchronous, active-high
- rd_addr_a / rd_addr_b  in  AW  read addresses
- rd_data_a / rd_data_b  out  DATA_W  read data, combinational
- rd_busy_a / rd_busy_b  out  1  addressed register has outstanding writes
- iss_en  in  1  issue: mark iss_addr as pending one more write
- iss_addr  in  AW  destination being issued
- iss_stall  out  1  counter of iss_addr saturated; issue refused
- wr_en0, wr_addr0, wr_data0  in  1/AW/DATA_W  writeback port 0 (ALU)
- wr_en1, wr_addr1, wr_data1  in  1/AW/DATA_W  writeback port 1 (load)

## Operation
- Storage: NREGS x DATA_W array plus NREGS x CNT_W counters cnt[r].
- Write: on rising edge, wr_enN writes wr_dataN to wr_addrN. Both ports, same address: port 1 data wins.
- Writes to registers with cnt==0 are legal and still update data; the counter stays 0.
- Counter update per edge, per register r: inc = iss_en && iss_addr==r && !iss_stall; dec = (wr_en0 && wr_addr0==r) + (wr_en1 && wr_addr1==r), range 0..2; cnt_next = max(0, cnt + inc - dec), computed in CNT_W+1 bits before clamping.
- iss_stall = iss_en && cnt[iss_addr]==2**CNT_W-1 (combinational, pre-edge value). A stalled issue leaves the counter unchanged; decode must hold and retry.
- Issue and writeback to the same register in one cycle: net change inc-dec, so 1 issue + 1 write leaves cnt unchanged.
- rd_busy_x = (cnt[rd_addr_x] != 0), using stored value (see Configuration).
- rd_data_x = stored array value (see Configuration).
- Reset (async, any time, including mid-write): all registers 0, all counters 0. Outputs: rd_data 0, rd_busy 0, iss_stall 0. Writes in the reset cycle are discarded.

## Timing
- Read latency 0 (combinational from address to data/busy).
- Write latency 1: data visible on reads the cycle after the wr_en edge (no bypass).
- Issue latency 1: rd_busy rises the cycle after an accepted iss_en.
- iss_stall valid in the same cycle as iss_en; no internal state machine beyond counters.
- Reset deassertion: first active edge may write and issue.

## Configuration
- RF_BYPASS_EN defined: write-to-read forwarding. If rd_addr_x matches an active write port, rd_data_x = that port's wr_data (port 1 over port 0). rd_busy_x is computed from the post-decrement count (cnt - dec, clamped at 0, ignoring same-cycle issue). Effective read latency for written data is 0.
- RF_BYPASS_EN undefined: no forwarding. rd_data and rd_busy reflect stored state only. Decode must wait one extra cycle after writeback.

## Test plan
- Reset then read all addresses -> rd_data 0 and rd_busy 0. Assert rst mid-write of r3=0xDEAD -> r3 reads 0 after reset.
- Issue r2, next cycle wr_en0 r2=0x12345678 -> rd_busy_a(r2)=1 for one cycle, then 0 with data 0x12345678. With bypass: busy=0 and data valid in the write cycle.
- Both ports write r5 (port0=0x1, port1=0x2) with cnt[r5]=2 -> r5=0x2, cnt=0. With cnt=1 -> clamps to 0.
- Issue r7 three times (CNT_W=2) -> 4th iss_en gives iss_stall=1 and cnt stays 3. Three writebacks -> busy clears after the third.
- Same-cycle iss_en r4 and wr_en1 r4=0xAA with cnt=1 -> cnt stays 1, r4=0xAA, rd_busy stays 1.
- Write r1 with cnt=0 -> data updates, cnt stays 0, rd_busy never asserts.
